key_debounce_array: RTL and testbench

KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

---
 rtl/key_pkg.sv | 17 +
 rtl/key_debounce_ch.sv | 96 +++++++++
 rtl/key_debounce_array.sv | 35 +++
 tb/tb_key_debounce_array.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared timing constants and counter-width helper for key debouncing
package key_pkg;

  localparam int CLK_HZ           = 50_000_000;
  // 20 ms debounce window at 50 MHz, expressed as the last counter value
  localparam int DEBOUNCE_CNT_MAX = 999_999;
  // 1 s long-press threshold at 50 MHz, expressed as the last counter value
  localparam int LONG_CNT_MAX     = 49_999_999;

  // Bits needed to hold values 0..n-1, never less than one bit
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key channel: synchronizer, debounce, hold timer, event pulses
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int CNT_MAX    = DEBOUNCE_CNT_MAX,
  parameter int LONG_MAX   = LONG_CNT_MAX,
  parameter int ACTIVE_LOW = 1
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_pin,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int DW = cnt_width(CNT_MAX + 1);
  // One extra code above LONG_MAX so the hold counter can park after firing
  localparam int HW = cnt_width(LONG_MAX + 2);

  localparam logic          IDLE_LVL  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [DW-1:0] DEB_LAST  = DW'(CNT_MAX);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MAX);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_MAX + 1);

  logic [1:0]    sync_q;
  logic          sample;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  logic          state_q;
  logic          press_q;
  logic          release_q;
  logic          long_q;
  logic          toggle;

  // XOR with the idle level turns the pin into 1 = pressed
  assign sample = sync_q[1] ^ IDLE_LVL;
  assign toggle = (sample != state_q) && (deb_cnt == DEB_LAST);

  // Two-flop synchronizer, reset to the released pin level
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_q <= {IDLE_LVL, IDLE_LVL};
    end else begin
      sync_q <= {sync_q[0], key_pin};
    end
  end

  // Debounce: count consecutive disagreeing samples, flip state after a full window
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      deb_cnt   <= '0;
      state_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      if (sample == state_q) begin
        deb_cnt <= '0;
      end else if (toggle) begin
        deb_cnt   <= '0;
        state_q   <= sample;
        press_q   <= sample;
        release_q <= ~sample;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  // Hold timer: runs while pressed, fires once, and a same-edge release wins over the long pulse
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      hold_cnt <= '0;
      long_q   <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (!state_q || toggle) begin
        hold_cnt <= '0;
      end else if (hold_cnt == HOLD_LAST) begin
        hold_cnt <= HOLD_SAT;
        long_q   <= 1'b1;
      end else if (hold_cnt != HOLD_SAT) begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end

  assign key_state   = state_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;

endmodule

// File: rtl/key_debounce_array.sv
// rtl/key_debounce_array.sv - array of independent debounced key channels
module key_debounce_array
  import key_pkg::*;
#(
  parameter int CH_NUM     = 4,
  parameter int CNT_MAX    = DEBOUNCE_CNT_MAX,
  parameter int LONG_MAX   = LONG_CNT_MAX,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [CH_NUM-1:0] key_in,
  output logic [CH_NUM-1:0] key_state,
  output logic [CH_NUM-1:0] key_press,
  output logic [CH_NUM-1:0] key_release,
  output logic [CH_NUM-1:0] key_long
);

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    key_debounce_ch #(
      .CNT_MAX   (CNT_MAX),
      .LONG_MAX  (LONG_MAX),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .key_pin    (key_in[i]),
      .key_state  (key_state[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// tb/tb_key_debounce_array.sv - directed self-checking bench for key_debounce_array
module tb_key_debounce_array;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [3:0] key_in;
  logic [3:0] key_state;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_long;

  int n_total = 0;
  int n_bad   = 0;

  int press_cnt [4];
  int rel_cnt   [4];
  int long_cnt  [4];
  int excl_viol = 0;

  int base_p;
  int base_r;
  int base_l;

  key_debounce_array #(
    .CH_NUM    (4),
    .CNT_MAX   (7),
    .LONG_MAX  (31),
    .ACTIVE_LOW(1)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 sys_clk = ~sys_clk;

  // pulse counters and one-event-per-channel watch, sampled mid-cycle
  initial begin
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
      long_cnt[i]  = 0;
    end
    forever begin
      @(negedge sys_clk);
      for (int i = 0; i < 4; i++) begin
        if (key_press[i])   press_cnt[i]++;
        if (key_release[i]) rel_cnt[i]++;
        if (key_long[i])    long_cnt[i]++;
        if (int'(key_press[i]) + int'(key_release[i]) + int'(key_long[i]) > 1) excl_viol++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    sys_rst = 1'b1;
    key_in  = 4'hF;
    tick(3);
    chk("rst_state",   32'(key_state),   32'h0);
    chk("rst_press",   32'(key_press),   32'h0);
    chk("rst_release", 32'(key_release), 32'h0);
    chk("rst_long",    32'(key_long),    32'h0);
    sys_rst = 1'b0;
    tick(5);

    // clean press on ch0: state and pulse exactly 10 edges later, one cycle wide
    key_in[0] = 1'b0;
    tick(9);
    chk("ch0_state_early", 32'(key_state[0]), 32'h0);
    chk("ch0_press_early", 32'(key_press[0]), 32'h0);
    tick(1);
    chk("ch0_state_on", 32'(key_state[0]), 32'h1);
    chk("ch0_press_on", 32'(key_press[0]), 32'h1);
    tick(1);
    chk("ch0_press_width", 32'(key_press[0]), 32'h0);
    chk("ch0_state_hold",  32'(key_state[0]), 32'h1);
    key_in[0] = 1'b1;
    tick(9);
    chk("ch0_rel_early", 32'(key_release[0]), 32'h0);
    tick(1);
    chk("ch0_rel_on",    32'(key_release[0]), 32'h1);
    chk("ch0_state_off", 32'(key_state[0]),   32'h0);
    tick(1);
    chk("ch0_rel_width", 32'(key_release[0]), 32'h0);

    // bounce on ch1: 5 low, 1 high, 5 low never completes a window
    base_p = press_cnt[1];
    base_r = rel_cnt[1];
    key_in[1] = 1'b0; tick(5);
    key_in[1] = 1'b1; tick(1);
    key_in[1] = 1'b0; tick(5);
    key_in[1] = 1'b1; tick(20);
    chk("ch1_bounce_state",   32'(key_state[1]),        32'h0);
    chk("ch1_bounce_press",   32'(press_cnt[1] - base_p), 32'h0);
    chk("ch1_bounce_release", 32'(rel_cnt[1] - base_r),   32'h0);

    // long press on ch2: key_long 32 cycles after key_press, once
    base_l = long_cnt[2];
    key_in[2] = 1'b0;
    tick(10);
    chk("ch2_press", 32'(key_press[2]), 32'h1);
    tick(31);
    chk("ch2_long_early", 32'(key_long[2]), 32'h0);
    tick(1);
    chk("ch2_long_on", 32'(key_long[2]), 32'h1);
    tick(1);
    chk("ch2_long_width", 32'(key_long[2]), 32'h0);
    tick(7);
    key_in[2] = 1'b1;
    tick(10);
    chk("ch2_long_release", 32'(key_release[2]), 32'h1);
    chk("ch2_long_once",    32'(long_cnt[2] - base_l), 32'h1);
    tick(5);

    // short hold on ch2: released before the threshold, no key_long
    base_l = long_cnt[2];
    key_in[2] = 1'b0;
    tick(10);
    chk("ch2_short_press", 32'(key_press[2]), 32'h1);
    tick(20);
    key_in[2] = 1'b1;
    tick(9);
    chk("ch2_short_rel_early", 32'(key_release[2]), 32'h0);
    tick(1);
    chk("ch2_short_rel_on", 32'(key_release[2]), 32'h1);
    tick(10);
    chk("ch2_short_no_long", 32'(long_cnt[2] - base_l), 32'h0);

    // all four channels together
    key_in = 4'h0;
    tick(10);
    chk("all_press", 32'(key_press), 32'hF);
    chk("all_state", 32'(key_state), 32'hF);
    tick(1);
    chk("all_press_width", 32'(key_press), 32'h0);
    key_in = 4'hF;
    tick(10);
    chk("all_release", 32'(key_release), 32'hF);
    tick(5);

    // reset at debounce count 5 with ch0 still held low
    base_p = press_cnt[0];
    key_in[0] = 1'b0;
    tick(7);
    sys_rst = 1'b1;
    tick(1);
    chk("midrst_state", 32'(key_state), 32'h0);
    chk("midrst_press", 32'(key_press), 32'h0);
    sys_rst = 1'b0;
    tick(9);
    chk("midrst_no_early_press", 32'(press_cnt[0] - base_p), 32'h0);
    tick(1);
    chk("midrst_press_on", 32'(key_press[0]), 32'h1);
    chk("midrst_state_on", 32'(key_state[0]), 32'h1);
    key_in[0] = 1'b1;
    tick(15);

    chk("pulse_exclusive", 32'(excl_viol), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
